find_star_bounds: RTL and testbench
===================================

# find_star_bounds

Parametrised bounding-box finder for a single star blob in the read-only frame memory. Given the seed pixel from the raster star search (the blob's top-most, left-most-on-that-row pixel), it probes memory one pixel at a time to find the blob's top, bottom, left and right extents, plus its centre. It sits between the star search and the downstream mapping/draw logic. It is the generalised successor of the fixed 60x60 top/bottom finder: it adds resolution and read-latency parameters and a left/right pass on the centre row.

## Interface
- X_RES, 60: image width in pixels.
- Y_RES, 60: image height in pixels.
- X_W, 6: x coordinate width; must satisfy 2^X_W >= X_RES.
- Y_W, 6: y coordinate width; must satisfy 2^Y_W >= Y_RES.
- ADDR_W, 12: memory address width; must satisfy 2^ADDR_W >= X_RES*Y_RES.
- PIX_W, 3: pixel data width.
- THRESHOLD, 0: a pixel belongs to the star iff its value > THRESHOLD.
- RD_LAT, 1: memory read latency in cycles (>= 1).
- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- xIn  in  X_W  seed x.
- yIn  in  Y_W  seed y.
- memAddr  out  ADDR_W  read address, computed as y*X_RES + x.
- pixVal  in  PIX_W  read data, valid RD_LAT cycles after memAddr.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results are valid from this cycle and held until the next accepted start.
- mostTop, mostBottom  out  Y_W  vertical extents.
- mostLeft, mostRight  out  X_W  horizontal extents.
- midX  out  X_W  centre column.
- midY  out  Y_W  centre row.

## Operation
- States: IDLE, SCAN_R0, SCAN_D, SCAN_L1, SCAN_R1, DONE.
- Each probe drives memAddr for one cycle, then waits RD_LAT cycles and evaluates pixVal. The probe therefore costs RD_LAT+1 cycles, and only one read is outstanding at a time.
- IDLE, start=1: latch seed; cur <- (xIn, yIn); mostTop <- yIn; go to SCAN_R0.
- SCAN_R0: scan right along the seed row.
  - If cur.x == X_RES-1, stop without probing.
  - Otherwise probe (cur.x+1, cur.y). If it is a star pixel, increment and repeat; if not, stop.
  - On stop, r0 <- cur.x and midX <- (xIn + r0) >> 1, computed in X_W+1 bits and truncated.
- SCAN_D: scan down column midX from yIn with the same rules, using edge Y_RES-1. On stop, mostBottom <- cur.y and midY <- (mostTop + mostBottom) >> 1 in Y_W+1 bits.
- SCAN_L1: scan left along row midY from midX. Stop at x == 0 or on a non-star pixel; mostLeft <- final x.
- SCAN_R1: scan right along row midY from midX. Stop at X_RES-1 or on a non-star pixel; mostRight <- final x.
- DONE: pulse done for one cycle, then return to IDLE.
- The seed and mid-point pixels are never re-read; they are taken as star pixels.
- No address outside 0..X_RES*Y_RES-1 is ever driven.
- start while busy is ignored, with no effect on the state or the results.
- resetn low at any time: immediate return to IDLE; every output register goes to 0, including memAddr, busy, done and all results. Any in-flight read data is discarded.

## Timing
- start is sampled at the rising edge in IDLE; busy=1 in the next cycle.
- Total probes P = sum of the probes of all passes. done is high exactly P*(RD_LAT+1)+2 cycles after the start edge.
- There is no extra cycle between passes: the first probe of the next pass is issued in the cycle after the previous pass's final evaluation.
- Results update only at the end of their own pass and are stable while done=1.

## Configuration
- FIND_STAR_LR_EN defined: SCAN_L1 and SCAN_R1 run as described above.
- FIND_STAR_LR_EN undefined:
  - SCAN_L1 and SCAN_R1 are not compiled in; SCAN_D goes straight to DONE.
  - mostLeft = xIn and mostRight = r0.
  - P covers only SCAN_R0 and SCAN_D.

## Test plan
- Rectangle: star at x 10..14, y 20..24, seed (10,20), RD_LAT=1.
  - Required: top 20, bottom 24, left 10, right 14, midX 12, midY 22.
  - P=16, so done is high 34 cycles after start.
- Plus shape: row 20 holds x 30..32; column 31 runs y 20..28; row 24 holds x 27..35; seed (30,20).
  - With FIND_STAR_LR_EN: left 27, right 35, bottom 28, midY 24.
  - Without it: left 30, right 32.
- Corner edge: star fills x 55..59, y 55..59, seed (55,55).
  - Required: right 59, bottom 59; memAddr never exceeds 3599.
- Single pixel: only (0,0) is lit, seed (0,0).
  - Required: all extents 0; SCAN_L1 issues no probe; P=3.
- Robustness: pulse start again mid-SCAN_D with a different seed -> the results belong to the first seed. Then pull resetn low during SCAN_R0 -> all outputs read 0 immediately, and no done pulse occurs.
- RD_LAT=3 on the rectangle case -> the same results, with done at 16*4+2 = 66 cycles.

Source files
------------

// File: rtl/find_star_bounds.sv
// find_star_bounds: bounding box and centre of one star blob in frame memory.
// Starting from the seed pixel (top-most, left-most on its row), probes memory
// one pixel at a time: right along the seed row, down the centre column, then
// (with FIND_STAR_LR_EN defined) left and right along the centre row.
// Only one read is ever in flight; each probe costs RD_LAT+1 cycles.
// Passes that would start on the image edge issue no probe and are resolved
// in the same cycle, so back-to-back passes never add idle cycles.
module find_star_bounds #(
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int X_W       = 6,
  parameter int Y_W       = 6,
  parameter int ADDR_W    = 12,
  parameter int PIX_W     = 3,
  parameter int THRESHOLD = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_W-1:0]    xIn,
  input  logic [Y_W-1:0]    yIn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [PIX_W-1:0]  pixVal,
  output logic              busy,
  output logic              done,
  output logic [Y_W-1:0]    mostTop,
  output logic [Y_W-1:0]    mostBottom,
  output logic [X_W-1:0]    mostLeft,
  output logic [X_W-1:0]    mostRight,
  output logic [X_W-1:0]    midX,
  output logic [Y_W-1:0]    midY
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [X_W-1:0] X_MAX = X_W'(X_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(Y_RES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_R0   = 3'd1;
  localparam logic [2:0] S_D    = 3'd2;
`ifdef FIND_STAR_LR_EN
  localparam logic [2:0] S_L1   = 3'd3;
  localparam logic [2:0] S_R1   = 3'd4;
`endif
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              pend_q, pend_d;     // a probe is in flight
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // read-latency countdown
  logic [X_W-1:0]    cx_q, cx_d;         // last confirmed star pixel of the pass
  logic [Y_W-1:0]    cy_q, cy_d;
  logic [X_W-1:0]    xs_q, xs_d;         // seed x
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [Y_W-1:0]    top_q, top_d, bot_q, bot_d, midy_q, midy_d;
  logic [X_W-1:0]    left_q, left_d, right_q, right_d, midx_q, midx_d;

  // Combinational scratch for the pass chaining below.
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic              star, fin_r0, fin_d, iss;
  logic [2:0]        iss_state;
  logic [ADDR_W-1:0] iss_addr;
`ifdef FIND_STAR_LR_EN
  logic              fin_l1, fin_r1;
`endif

  function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);
  endfunction

  // Next-state: evaluate the outstanding probe, then close finished passes in
  // order and issue the first probe of whichever pass can actually probe.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    xs_d      = xs_q;
    addr_d    = addr_q;
    top_d     = top_q;
    bot_d     = bot_q;
    left_d    = left_q;
    right_d   = right_q;
    midx_d    = midx_q;
    midy_d    = midy_q;
    cx        = cx_q;
    cy        = cy_q;
    star      = 1'b0;
    fin_r0    = 1'b0;
    fin_d     = 1'b0;
    iss       = 1'b0;
    iss_state = state_q;
    iss_addr  = addr_q;
`ifdef FIND_STAR_LR_EN
    fin_l1    = 1'b0;
    fin_r1    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_R0;
          pend_d  = 1'b0;
          cx      = xIn;
          cy      = yIn;
          xs_d    = xIn;
          top_d   = yIn;
        end
      end
      default: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else if (!pend_q) begin
          // First cycle after start: open the right scan on the seed row.
          if (cx == X_MAX) fin_r0 = 1'b1;
          else begin
            iss = 1'b1; iss_state = S_R0; iss_addr = addr_of(cx + X_W'(1), cy);
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pend_d = 1'b0;
          star   = pixVal > PIX_W'(THRESHOLD);
          case (state_q)
            S_R0: begin
              if (!star) fin_r0 = 1'b1;
              else begin
                cx = cx + X_W'(1);
                if (cx == X_MAX) fin_r0 = 1'b1;
                else begin
                  iss = 1'b1; iss_state = S_R0; iss_addr = addr_of(cx + X_W'(1), cy);
                end
              end
            end
            S_D: begin
              if (!star) fin_d = 1'b1;
              else begin
                cy = cy + Y_W'(1);
                if (cy == Y_MAX) fin_d = 1'b1;
                else begin
                  iss = 1'b1; iss_state = S_D; iss_addr = addr_of(cx, cy + Y_W'(1));
                end
              end
            end
`ifdef FIND_STAR_LR_EN
            S_L1: begin
              if (!star) fin_l1 = 1'b1;
              else begin
                cx = cx - X_W'(1);
                if (cx == '0) fin_l1 = 1'b1;
                else begin
                  iss = 1'b1; iss_state = S_L1; iss_addr = addr_of(cx - X_W'(1), cy);
                end
              end
            end
            S_R1: begin
              if (!star) fin_r1 = 1'b1;
              else begin
                cx = cx + X_W'(1);
                if (cx == X_MAX) fin_r1 = 1'b1;
                else begin
                  iss = 1'b1; iss_state = S_R1; iss_addr = addr_of(cx + X_W'(1), cy);
                end
              end
            end
`endif
            default: ;
          endcase
        end
      end
    endcase

    // Seed row finished: centre column, then scan down it from the seed row.
    if (fin_r0) begin
      midx_d = X_W'(({1'b0, xs_q} + {1'b0, cx}) >> 1);
`ifndef FIND_STAR_LR_EN
      left_d  = xs_q;
      right_d = cx;
`endif
      cx = midx_d;
      cy = top_q;
      if (cy == Y_MAX) fin_d = 1'b1;
      else begin
        iss = 1'b1; iss_state = S_D; iss_addr = addr_of(cx, cy + Y_W'(1));
      end
    end

    // Column finished: centre row is known.
    if (fin_d) begin
      bot_d  = cy;
      midy_d = Y_W'(({1'b0, top_q} + {1'b0, cy}) >> 1);
`ifdef FIND_STAR_LR_EN
      cx = midx_d;
      cy = midy_d;
      if (cx == '0) fin_l1 = 1'b1;
      else begin
        iss = 1'b1; iss_state = S_L1; iss_addr = addr_of(cx - X_W'(1), cy);
      end
`else
      state_d = S_DONE;
`endif
    end

`ifdef FIND_STAR_LR_EN
    if (fin_l1) begin
      left_d = cx;
      cx     = midx_d;
      if (cx == X_MAX) fin_r1 = 1'b1;
      else begin
        iss = 1'b1; iss_state = S_R1; iss_addr = addr_of(cx + X_W'(1), cy);
      end
    end

    if (fin_r1) begin
      right_d = cx;
      state_d = S_DONE;
    end
`endif

    if (iss) begin
      state_d = iss_state;
      pend_d  = 1'b1;
      cnt_d   = CNT_W'(RD_LAT);
      addr_d  = iss_addr;
    end

    cx_d   = cx;
    cy_d   = cy;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State and output registers; reset clears everything, dropping any read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xs_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      top_q   <= '0;
      bot_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      midx_q  <= '0;
      midy_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xs_q    <= xs_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      left_q  <= left_d;
      right_q <= right_d;
      midx_q  <= midx_d;
      midy_q  <= midy_d;
    end
  end

  assign memAddr    = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mostTop    = top_q;
  assign mostBottom = bot_q;
  assign mostLeft   = left_q;
  assign mostRight  = right_q;
  assign midX       = midx_q;
  assign midY       = midy_q;

endmodule

// File: tb/tb_find_star_bounds.sv
// Directed bench for find_star_bounds: two instances (RD_LAT=1 and 3) read a
// shared 60x60 frame through read-latency pipelines.
module tb_find_star_bounds;
`ifdef FIND_STAR_LR_EN
  localparam bit LR = 1'b1;
`else
  localparam bit LR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b1;
  logic        s1 = 1'b0, s3 = 1'b0;
  logic [5:0]  x1 = '0, y1 = '0, x3 = '0, y3 = '0;
  logic [11:0] a1, a3;
  logic [2:0]  p1, p3;
  logic        b1, b3, d1, d3;
  logic [5:0]  t1, bo1, l1, r1, mx1, my1;
  logic [5:0]  t3, bo3, l3, r3, mx3, my3;

  logic [2:0] frame [0:3599];
  logic [2:0] q1;
  logic [2:0] q3 [0:2];

  int errors = 0;
  int checks = 0;

  find_star_bounds #(.RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(s1), .xIn(x1), .yIn(y1),
    .memAddr(a1), .pixVal(p1), .busy(b1), .done(d1),
    .mostTop(t1), .mostBottom(bo1), .mostLeft(l1), .mostRight(r1),
    .midX(mx1), .midY(my1));

  find_star_bounds #(.RD_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .start(s3), .xIn(x3), .yIn(y3),
    .memAddr(a3), .pixVal(p3), .busy(b3), .done(d3),
    .mostTop(t3), .mostBottom(bo3), .mostLeft(l3), .mostRight(r3),
    .midX(mx3), .midY(my3));

  // Synchronous frame memory with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    q1    <= (a1 < 12'd3600) ? frame[a1] : 3'd0;
    q3[0] <= (a3 < 12'd3600) ? frame[a3] : 3'd0;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign p1 = q1;
  assign p3 = q3[2];

  task automatic clear_frame();
    for (int i = 0; i < 3600; i++) frame[i] = 3'd0;
  endtask

  task automatic fill(input int xa, input int xb, input int ya, input int yb, input logic [2:0] v);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) frame[y*60 + x] = v;
  endtask

  // Start one search and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run(input int which, input int sx, input int sy, output int lat, output int maxa);
    logic bz;
    lat = -1; maxa = 0;
    @(negedge clk);
    if (which == 1) begin x1 = 6'(sx); y1 = 6'(sy); s1 = 1'b1; end
    else begin x3 = 6'(sx); y3 = 6'(sy); s3 = 1'b1; end
    @(posedge clk); #1;
    s1 = 1'b0; s3 = 1'b0;
    bz = (which == 1) ? b1 : b3;
    if (bz !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", bz); end
    checks++;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (which == 1) begin
        if (int'(a1) > maxa) maxa = int'(a1);
        if (d1 === 1'b1) begin lat = n; break; end
      end else begin
        if (int'(a3) > maxa) maxa = int'(a3);
        if (d3 === 1'b1) begin lat = n; break; end
      end
    end
    if (lat < 0) begin errors++; $display("FAIL done_timeout: no done within 400 cycles"); end
    checks++;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (a1 !== 12'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", a1); end
    checks++;
    if ({b1, d1, t1, bo1, l1, r1, mx1, my1} !== '0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", {b1, d1, t1, bo1, l1, r1, mx1, my1});
    end
    checks++;
    if ({a3, b3, d3, t3, bo3, l3, r3, mx3, my3} !== '0) begin
      errors++; $display("FAIL reset_outs3: got %h want 0", {a3, b3, d3, t3, bo3, l3, r3, mx3, my3});
    end
    checks++;
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rect();
    int lat, maxa;
    clear_frame(); fill(10, 14, 20, 24, 3'd5);
    run(1, 10, 20, lat, maxa);
    if (t1 !== 6'd20)  begin errors++; $display("FAIL rect_top: got %0d want 20", t1); end
    if (bo1 !== 6'd24) begin errors++; $display("FAIL rect_bottom: got %0d want 24", bo1); end
    if (l1 !== 6'd10)  begin errors++; $display("FAIL rect_left: got %0d want 10", l1); end
    if (r1 !== 6'd14)  begin errors++; $display("FAIL rect_right: got %0d want 14", r1); end
    if (mx1 !== 6'd12) begin errors++; $display("FAIL rect_midx: got %0d want 12", mx1); end
    if (my1 !== 6'd22) begin errors++; $display("FAIL rect_midy: got %0d want 22", my1); end
    if (lat != (LR ? 34 : 22)) begin errors++; $display("FAIL rect_latency: got %0d want %0d", lat, LR ? 34 : 22); end
    checks += 7;
    // Results must hold after the done pulse.
    repeat (3) @(posedge clk); #1;
    if ({t1, bo1, mx1, my1} !== {6'd20, 6'd24, 6'd12, 6'd22}) begin
      errors++; $display("FAIL rect_hold: got %h want %h", {t1, bo1, mx1, my1}, {6'd20, 6'd24, 6'd12, 6'd22});
    end
    if (d1 !== 1'b0) begin errors++; $display("FAIL rect_done_pulse: got %b want 0", d1); end
    checks += 2;
  endtask

  task automatic test_plus();
    int lat, maxa;
    clear_frame();
    fill(30, 32, 20, 20, 3'd1);   // value 1 is just above threshold
    fill(31, 31, 20, 28, 3'd3);
    fill(27, 35, 24, 24, 3'd7);
    run(1, 30, 20, lat, maxa);
    if (bo1 !== 6'd28) begin errors++; $display("FAIL plus_bottom: got %0d want 28", bo1); end
    if (my1 !== 6'd24) begin errors++; $display("FAIL plus_midy: got %0d want 24", my1); end
    if (mx1 !== 6'd31) begin errors++; $display("FAIL plus_midx: got %0d want 31", mx1); end
    if (l1 !== (LR ? 6'd27 : 6'd30)) begin errors++; $display("FAIL plus_left: got %0d want %0d", l1, LR ? 27 : 30); end
    if (r1 !== (LR ? 6'd35 : 6'd32)) begin errors++; $display("FAIL plus_right: got %0d want %0d", r1, LR ? 35 : 32); end
    if (lat != (LR ? 46 : 26)) begin errors++; $display("FAIL plus_latency: got %0d want %0d", lat, LR ? 46 : 26); end
    checks += 6;
  endtask

  task automatic test_corner();
    int lat, maxa;
    clear_frame(); fill(55, 59, 55, 59, 3'd4);
    run(1, 55, 55, lat, maxa);
    if (r1 !== 6'd59)  begin errors++; $display("FAIL corner_right: got %0d want 59", r1); end
    if (bo1 !== 6'd59) begin errors++; $display("FAIL corner_bottom: got %0d want 59", bo1); end
    if (l1 !== 6'd55)  begin errors++; $display("FAIL corner_left: got %0d want 55", l1); end
    if ({mx1, my1} !== {6'd57, 6'd57}) begin errors++; $display("FAIL corner_mid: got %0d,%0d want 57,57", mx1, my1); end
    if (maxa > 3599)   begin errors++; $display("FAIL corner_addr: got %0d want <=3599", maxa); end
    if (lat != (LR ? 28 : 18)) begin errors++; $display("FAIL corner_latency: got %0d want %0d", lat, LR ? 28 : 18); end
    checks += 6;
  endtask

  task automatic test_single();
    int lat, maxa;
    clear_frame(); frame[0] = 3'd7;
    run(1, 0, 0, lat, maxa);
    if ({t1, bo1, l1, r1, mx1, my1} !== '0) begin
      errors++; $display("FAIL single_extents: got %h want 0", {t1, bo1, l1, r1, mx1, my1});
    end
    if (lat != (LR ? 8 : 6)) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LR ? 8 : 6); end
    checks += 2;
  endtask

  task automatic test_robust();
    int lat;
    bit seen;
    clear_frame(); fill(10, 14, 20, 24, 3'd5);
    lat = -1;
    @(negedge clk); x1 = 6'd10; y1 = 6'd20; s1 = 1'b1;
    @(posedge clk); #1; s1 = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (n == 15) begin x1 = 6'd40; y1 = 6'd5; s1 = 1'b1; end   // mid column scan
      else s1 = 1'b0;
      @(posedge clk); #1;
      if (d1 === 1'b1) begin lat = n; break; end
    end
    s1 = 1'b0;
    if (lat != (LR ? 34 : 22)) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LR ? 34 : 22); end
    if ({t1, bo1, mx1, my1, l1, r1} !== {6'd20, 6'd24, 6'd12, 6'd22, 6'd10, 6'd14}) begin
      errors++; $display("FAIL busy_start_results: got %h want %h", {t1, bo1, mx1, my1, l1, r1},
                         {6'd20, 6'd24, 6'd12, 6'd22, 6'd10, 6'd14});
    end
    checks += 2;
    // Reset in the middle of the seed-row scan.
    @(negedge clk); x1 = 6'd10; y1 = 6'd20; s1 = 1'b1;
    @(posedge clk); #1; s1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    if (a1 !== 12'd0) begin errors++; $display("FAIL midreset_addr: got %0d want 0", a1); end
    if (b1 !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b want 0", b1); end
    if ({d1, t1, bo1, l1, r1, mx1, my1} !== '0) begin
      errors++; $display("FAIL midreset_results: got %h want 0", {d1, t1, bo1, l1, r1, mx1, my1});
    end
    checks += 3;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (d1 === 1'b1 || b1 === 1'b1) seen = 1'b1;
    end
    if (seen) begin errors++; $display("FAIL midreset_no_done: got activity want none"); end
    checks++;
  endtask

  task automatic test_lat3();
    int lat, maxa;
    clear_frame(); fill(10, 14, 20, 24, 3'd2);
    run(3, 10, 20, lat, maxa);
    if ({t3, bo3, l3, r3} !== {6'd20, 6'd24, 6'd10, 6'd14}) begin
      errors++; $display("FAIL lat3_extents: got %h want %h", {t3, bo3, l3, r3}, {6'd20, 6'd24, 6'd10, 6'd14});
    end
    if ({mx3, my3} !== {6'd12, 6'd22}) begin errors++; $display("FAIL lat3_mid: got %0d,%0d want 12,22", mx3, my3); end
    if (lat != (LR ? 66 : 42)) begin errors++; $display("FAIL lat3_latency: got %0d want %0d", lat, LR ? 66 : 42); end
    checks += 3;
  endtask

  initial begin
    clear_frame();
    test_reset();
    test_rect();
    test_plus();
    test_corner();
    test_single();
    test_robust();
    test_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
